// File: rtl/multi_warp_reg_file.sv
// Shared vector register file for all warps of a compute unit.
// Storage is one RAM per lane indexed by {warp, reg}; specials (r0, thread id,
// block id, block size) are muxed in on read. Registered dual-operand read,
// masked write-back with same-cycle bypass, per-warp pending-write scoreboard,
// and a clear sequencer for power-up and per-warp re-initialisation.

module mwrf_lane #(
  parameter int DW    = 32,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);
  logic [DW-1:0] mem [DEPTH];

  // GPR storage has no reset; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

module multi_warp_reg_file #(
  parameter int NUM_WARPS        = 4,
  parameter int THREADS_PER_WARP = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_REGS         = 32,
  localparam int WW = $clog2(NUM_WARPS),
  localparam int RW = $clog2(NUM_REGS),
  localparam int LW = THREADS_PER_WARP*DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        init_valid,
  input  logic [WW-1:0]               init_warp,
  input  logic [DATA_WIDTH-1:0]       init_block_id,
  input  logic [DATA_WIDTH-1:0]       init_block_size,
  output logic                        busy,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [WW-1:0]               rd_warp,
  input  logic [RW-1:0]               rd_rs1,
  input  logic [RW-1:0]               rd_rs2,
  output logic                        rd_hazard,
  output logic                        rsp_valid,
  output logic [LW-1:0]               rsp_rs1,
  output logic [LW-1:0]               rsp_rs2,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [WW-1:0]               wr_warp,
  input  logic [RW-1:0]               wr_rd,
  input  logic [THREADS_PER_WARP-1:0] wr_mask,
  input  logic [LW-1:0]               wr_data,
  input  logic                        issue_valid,
  input  logic [WW-1:0]               issue_warp,
  input  logic [RW-1:0]               issue_rd
);
  localparam int AW = WW + RW;
  localparam logic [RW-1:0] R_LAST_GPR = RW'(NUM_REGS-4);
  localparam logic [RW-1:0] R_TID      = RW'(NUM_REGS-3);
  localparam logic [RW-1:0] R_BID      = RW'(NUM_REGS-2);
  localparam logic [RW-1:0] R_BSZ      = RW'(NUM_REGS-1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR_ALL, S_CLEAR_WARP} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] clr_warp, clr_warp_nxt;
  logic [RW-1:0] clr_reg, clr_reg_nxt;

  logic [NUM_WARPS-1:0][DATA_WIDTH-1:0] blk_id, blk_sz;
  logic [NUM_WARPS-1:0][NUM_REGS-1:0]   pend;
  logic [LW-1:0] rs1_d, rs2_d;
  logic rd_acc, wr_acc, init_acc;

  function automatic logic is_gpr(input logic [RW-1:0] r);
    return (r != '0) && (r <= R_LAST_GPR);
  endfunction

  assign busy      = (state != S_IDLE);
  assign rd_ready  = !busy;
  assign wr_ready  = !busy;
  assign rd_acc    = rd_valid && rd_ready;
  assign wr_acc    = wr_valid && wr_ready;
  assign init_acc  = init_valid && (state == S_IDLE);
  assign rd_hazard = pend[rd_warp][rd_rs1] | pend[rd_warp][rd_rs2];

  // Clear sequencer state register; reset always restarts the full sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_CLEAR_ALL;
      clr_warp <= '0;
      clr_reg  <= RW'(1);
    end else begin
      state    <= state_nxt;
      clr_warp <= clr_warp_nxt;
      clr_reg  <= clr_reg_nxt;
    end
  end

  // Sweep GPR indices one per cycle; CLEAR_ALL walks every warp, CLEAR_WARP one.
  always_comb begin
    state_nxt    = state;
    clr_warp_nxt = clr_warp;
    clr_reg_nxt  = clr_reg;
    case (state)
      S_IDLE: if (init_valid) begin
        state_nxt    = S_CLEAR_WARP;
        clr_warp_nxt = init_warp;
        clr_reg_nxt  = RW'(1);
      end
      default: begin
        if (clr_reg == R_LAST_GPR) begin
          clr_reg_nxt = RW'(1);
          if (state == S_CLEAR_ALL && clr_warp != '1) clr_warp_nxt = clr_warp + 1'b1;
          else                                          state_nxt    = S_IDLE;
        end else begin
          clr_reg_nxt = clr_reg + 1'b1;
        end
      end
    endcase
  end

  // Per-warp block id/size, latched when an init is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_id <= '0;
      blk_sz <= '0;
    end else if (init_acc) begin
      blk_id[init_warp] <= init_block_id;
      blk_sz[init_warp] <= init_block_size;
    end
  end

  // Scoreboard: init clears a row, write clears a bit, issue sets (set wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      if (init_acc) pend[init_warp] <= '0;
      if (wr_acc) pend[wr_warp][wr_rd] <= 1'b0;
      if (issue_valid && is_gpr(issue_rd)) pend[issue_warp][issue_rd] <= 1'b1;
    end
  end

  // RAM write port shared by clear sweep (while busy) and write-back.
  logic [AW-1:0] waddr;
  assign waddr = busy ? {clr_warp, clr_reg} : {wr_warp, wr_rd};

  function automatic logic [DATA_WIDTH-1:0] opnd(
    input logic [RW-1:0] rs, input logic [DATA_WIDTH-1:0] ram,
    input logic [DATA_WIDTH-1:0] tid, input logic [DATA_WIDTH-1:0] bid,
    input logic [DATA_WIDTH-1:0] bsz, input logic byp,
    input logic [DATA_WIDTH-1:0] bdata);
    if (rs == '0)         return '0;
    else if (rs == R_TID) return tid;
    else if (rs == R_BID) return bid;
    else if (rs == R_BSZ) return bsz;
    else if (byp)         return bdata;
    else                  return ram;
  endfunction

  for (genvar i = 0; i < THREADS_PER_WARP; i++) begin : g_lane
    logic                  we, byp1, byp2;
    logic [DATA_WIDTH-1:0] wd, ram1, ram2, tid;

    assign we   = !reset && (busy || (wr_acc && wr_mask[i] && is_gpr(wr_rd)));
    assign wd   = busy ? '0 : wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign tid  = DATA_WIDTH'(rd_warp) * DATA_WIDTH'(THREADS_PER_WARP) + DATA_WIDTH'(i);
    assign byp1 = wr_acc && wr_mask[i] && (wr_warp == rd_warp) && (wr_rd == rd_rs1);
    assign byp2 = wr_acc && wr_mask[i] && (wr_warp == rd_warp) && (wr_rd == rd_rs2);

    mwrf_lane #(.DW(DATA_WIDTH), .DEPTH(NUM_WARPS*NUM_REGS), .AW(AW)) u_lane (
      .clk     (clk),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wd),
      .raddr_a ({rd_warp, rd_rs1}),
      .raddr_b ({rd_warp, rd_rs2}),
      .rdata_a (ram1),
      .rdata_b (ram2)
    );

    assign rs1_d[i*DATA_WIDTH +: DATA_WIDTH] =
      opnd(rd_rs1, ram1, tid, blk_id[rd_warp], blk_sz[rd_warp], byp1, wd);
    assign rs2_d[i*DATA_WIDTH +: DATA_WIDTH] =
      opnd(rd_rs2, ram2, tid, blk_id[rd_warp], blk_sz[rd_warp], byp2, wd);
  end

  // Registered operand response; data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rs1   <= '0;
      rsp_rs2   <= '0;
    end else begin
      rsp_valid <= rd_acc;
      if (rd_acc) begin
        rsp_rs1 <= rs1_d;
        rsp_rs2 <= rs2_d;
      end
    end
  end
endmodule
